// File: rtl/bus_comp_pkg.sv
`default_nettype none
// ============================================================================
// bus_comp_pkg : shared encodings for the bus comparator sequencer
// Revision     : 1.0
// ============================================================================
package bus_comp_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_CRC  = 2'd1,
    M_COMP = 2'd2,
    M_OUT  = 2'd3
  } main_st_e;

  typedef enum logic [1:0] {
    C_WAIT  = 2'd0,
    C_WRITE = 2'd1,
    C_READ  = 2'd2,
    C_READY = 2'd3
  } cap_st_e;

  // Status field codes: {pending, err}
  localparam logic [1:0] ST_IDLE = 2'b11;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_PASS = 2'b00;
  localparam logic [1:0] ST_FAIL = 2'b01;

  localparam int OUT_LSB  = 0;
  localparam int COMP_LSB = 2;

  function automatic int crc_lsb(input int ch);
    return 4 + 2 * ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cap_chan.sv
`default_nettype none
// ============================================================================
// bus_cap_chan : per-channel strobe capture FSM and word register
// Revision     : 1.0
// ============================================================================
module bus_cap_chan
  import bus_comp_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic          ready,
  output logic          active,
  output logic [DW-1:0] dout
);

  cap_st_e       state_q;
  logic [DW-1:0] word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_WAIT;
      word_q  <= '0;
    end else if (clr) begin
      state_q <= C_WAIT;
    end else if (run) begin
      case (state_q)
        C_WAIT:  if (!en) state_q <= C_WRITE;
        C_WRITE: if (en)  state_q <= C_READ;
        C_READ: begin
          state_q <= C_READY;
          word_q  <= din;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign ready  = (state_q == C_READY);
  assign active = (state_q != C_WAIT);
  assign dout   = word_q;

endmodule
`default_nettype wire

// File: rtl/bus_comp_seq_nch.sv
`default_nettype none
// ============================================================================
// bus_comp_seq_nch : NCH-channel capture, CRC -> compare -> output sequencer
// Revision         : 1.0
// ============================================================================
module bus_comp_seq_nch
  import bus_comp_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = 64,
  parameter int TMO_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      data_en,
  input  logic [NCH*DW-1:0]   data_in,
  input  logic [2*NCH-1:0]    crc_status,
  input  logic [1:0]          comp_status,
  input  logic [1:0]          out_status,
  output logic [NCH-1:0]      crc_en,
  output logic                comp_en,
  output logic                out_en,
  output logic [NCH*DW-1:0]   data_out,
  output logic [2*NCH+3:0]    mod_status,
  output logic                done,
  output logic                timeout
);

  localparam int             WDW    = $clog2(TMO_CYC + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TMO_CYC);

  main_st_e         state_q;
  logic [NCH-1:0]   crc_en_q;
  logic             comp_en_q, out_en_q, done_q, timeout_q;
  logic [2*NCH+3:0] stat_q;
  logic [WDW-1:0]   wd_q;

  logic [NCH-1:0]   ready, active;
  logic             all_ready, cap_busy, wd_hit, cap_run, cap_clr, crc_any_err;

  assign all_ready = &ready;
  assign cap_busy  = (|active) && !all_ready;
  assign wd_hit    = (wd_q == WD_MAX);
  assign cap_run   = (state_q == M_IDLE);
  assign cap_clr   = cap_run && (all_ready || (cap_busy && wd_hit));

  always_comb begin
    crc_any_err = 1'b0;
    for (int i = 0; i < NCH; i++) crc_any_err = crc_any_err | stat_q[crc_lsb(i)];
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      bus_cap_chan #(.DW(DW)) u_chan (
        .clk    (clk),
        .rst    (rst),
        .run    (cap_run),
        .clr    (cap_clr),
        .en     (data_en[i]),
        .din    (data_in[i*DW +: DW]),
        .ready  (ready[i]),
        .active (active[i]),
        .dout   (data_out[i*DW +: DW])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= M_IDLE;
      crc_en_q  <= '1;
      comp_en_q <= 1'b1;
      out_en_q  <= 1'b1;
      stat_q    <= '1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (!wd_hit) wd_q <= wd_q + WDW'(1);
      case (state_q)
        M_IDLE: begin
          if (all_ready) begin
            state_q  <= M_CRC;
            crc_en_q <= '0;
            wd_q     <= '0;
            stat_q   <= '1;
            for (int i = 0; i < NCH; i++) stat_q[crc_lsb(i) +: 2] <= ST_RUN;
          end else if (!cap_busy) begin
            wd_q <= '0;
          end else if (wd_hit) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            wd_q      <= '0;
            for (int i = 0; i < NCH; i++) stat_q[crc_lsb(i) +: 2] <= ST_FAIL;
          end
        end
        M_CRC: begin
          for (int i = 0; i < NCH; i++) begin
            if (!crc_en_q[i] && !crc_status[2*i+1]) begin
              stat_q[crc_lsb(i) +: 2] <= {1'b0, crc_status[2*i]};
              crc_en_q[i]             <= 1'b1;
            end
          end
          // Decide on the registered fields once every channel has finished
          if (&crc_en_q) begin
            wd_q <= '0;
            if (crc_any_err) begin
              out_en_q                <= 1'b0;
              stat_q[OUT_LSB +: 2]    <= ST_RUN;
              state_q                 <= M_OUT;
            end else begin
              comp_en_q               <= 1'b0;
              stat_q[COMP_LSB +: 2]   <= ST_RUN;
              state_q                 <= M_COMP;
            end
          end else if (wd_hit) begin
            for (int i = 0; i < NCH; i++) begin
              if (!crc_en_q[i]) begin
                stat_q[crc_lsb(i) +: 2] <= ST_FAIL;
                crc_en_q[i]             <= 1'b1;
              end
            end
            timeout_q            <= 1'b1;
            out_en_q             <= 1'b0;
            stat_q[OUT_LSB +: 2] <= ST_RUN;
            state_q              <= M_OUT;
            wd_q                 <= '0;
          end
        end
        M_COMP: begin
          if (!comp_status[1] || wd_hit) begin
            stat_q[COMP_LSB +: 2] <= comp_status[1] ? ST_FAIL : comp_status;
            timeout_q             <= comp_status[1];
            comp_en_q             <= 1'b1;
            out_en_q              <= 1'b0;
            stat_q[OUT_LSB +: 2]  <= ST_RUN;
            state_q               <= M_OUT;
            wd_q                  <= '0;
          end
        end
        M_OUT: begin
          if (!out_status[1] || wd_hit) begin
            stat_q[OUT_LSB +: 2] <= out_status[1] ? ST_FAIL : out_status;
            timeout_q            <= out_status[1];
            out_en_q             <= 1'b1;
            done_q               <= 1'b1;
            state_q              <= M_IDLE;
            wd_q                 <= '0;
          end
        end
        default: state_q <= M_IDLE;
      endcase
    end
  end

  assign crc_en     = crc_en_q;
  assign comp_en    = comp_en_q;
  assign out_en     = out_en_q;
  assign mod_status = stat_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire
